fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage_pc_reg.sv | 27 ++
 rtl/fetch_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the fetch stage: reset PC, instruction
// memory window, NOP encoding and the D-register update selector.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        D_LOAD   = 2'd0,
        D_HOLD   = 2'd1,
        D_BUBBLE = 2'd2
    } d_action_e;

    // The limit is 33 bits wide so that a window ending at 4 GiB does not wrap.
    function automatic logic addr_illegal(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [32:0] limit);
        addr_illegal = (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: NPC/hazard/IM inputs and the D-register outputs.
interface fetch_stage_if;

    logic [31:0] NPC;
    logic        stall;
    logic        D_clr;
    logic [31:0] F_instr;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_err;
    logic [31:0] fetch_cnt;

    modport master (
        output NPC, stall, D_clr, F_instr,
        input  F_PC, D_PC, D_instr, D_valid, D_err, fetch_cnt
    );

    modport slave (
        input  NPC, stall, D_clr, F_instr,
        output F_PC, D_PC, D_instr, D_valid, D_err, fetch_cnt
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register with synchronous reset and load enable.
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] q_r;

    // PC state: reset wins, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= RESET_VAL;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the F/D pipeline register with
// stall/bubble control, illegal-address flagging and an accepted-fetch counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.slave fif
);

    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    logic [31:0] f_pc_s;
    logic        f_err_s;
    logic        pc_en_s;
    d_action_e   d_act_s;

    logic [31:0] d_pc_r;
    logic [31:0] d_instr_r;
    logic        d_valid_r;
    logic        d_err_r;
    logic [31:0] fetch_cnt_r;

    assign pc_en_s = ~fif.stall;

    pc_reg #(
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en_s),
        .d     (fif.NPC),
        .q     (f_pc_s)
    );

    assign f_err_s = addr_illegal(f_pc_s, IM_BASE, IM_LIMIT);

    // D-register action select; a bubble overrides a stall so the frozen instruction is dropped.
    always_comb begin
        d_act_s = D_HOLD;
        if (fif.D_clr) begin
            d_act_s = D_BUBBLE;
        end else if (fif.stall) begin
            d_act_s = D_HOLD;
        end else begin
            d_act_s = D_LOAD;
        end
    end

    // D pipeline register and accepted-fetch counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_pc_r      <= PC_RESET;
            d_instr_r   <= NOP_INSTR;
            d_valid_r   <= 1'b0;
            d_err_r     <= 1'b0;
            fetch_cnt_r <= 32'd0;
        end else begin
            case (d_act_s)
                D_LOAD: begin
                    d_pc_r      <= f_pc_s;
                    d_instr_r   <= f_err_s ? NOP_INSTR : fif.F_instr;
                    d_valid_r   <= 1'b1;
                    d_err_r     <= f_err_s;
                    fetch_cnt_r <= fetch_cnt_r + 32'd1;
                end
                D_BUBBLE: begin
                    // Keep the PC so a downstream exception still reports a sensible address.
                    d_pc_r      <= f_pc_s;
                    d_instr_r   <= NOP_INSTR;
                    d_valid_r   <= 1'b0;
                    d_err_r     <= 1'b0;
                    fetch_cnt_r <= fetch_cnt_r;
                end
                default: begin
                    d_pc_r      <= d_pc_r;
                    d_instr_r   <= d_instr_r;
                    d_valid_r   <= d_valid_r;
                    d_err_r     <= d_err_r;
                    fetch_cnt_r <= fetch_cnt_r;
                end
            endcase
        end
    end

    assign fif.F_PC      = f_pc_s;
    assign fif.D_PC      = d_pc_r;
    assign fif.D_instr   = d_instr_r;
    assign fif.D_valid   = d_valid_r;
    assign fif.D_err     = d_err_r;
    assign fif.fetch_cnt = fetch_cnt_r;

endmodule
